wb_write_responder: RTL and testbench

- Responder end of the writeback→register-file four-phase req/ack handshake.
- Accepts write transfers (we, rd, result) from the writeback stage and buffers them in a small FIFO.
- Drains the FIFO as single-cycle write strobes into the register-file array port.
- Flags read/write hazards on pending writes to the decode stage's read addresses.

---
 rtl/async_cpu_pkg.sv | 14 +
 rtl/wb_fifo.sv | 99 +++++++++
 rtl/wb_write_responder.sv | 125 ++++++++++++
 tb/tb_wb_write_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/async_cpu_pkg.sv
// Shared definitions for the writeback -> register-file path.
//   DATA_W_DEF / ADDR_W_DEF : default register data / address widths
//   hs_state_t              : four-phase responder handshake states
package async_cpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic {
    HS_IDLE  = 1'b0,
    HS_ACKED = 1'b1
  } hs_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of {addr, data} register writes.
// Every entry's valid flag and address are exposed so that the parent can
// compare pending writes against read addresses.
//   clk, rst        : clock, synchronous active-low reset
//   push_i          : enqueue {push_addr_i, push_data_i} (ignored when full)
//   pop_i           : dequeue the head entry (ignored when empty)
//   head_addr_o/_data_o : head entry contents (raw storage, not gated)
//   full_o, empty_o : registered occupancy flags
//   ent_valid_o     : per-slot valid flag, indexed by storage slot
//   ent_addr_o      : per-slot stored address
module wb_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push_ok, pop_ok;

  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is derived from pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    head_addr_o = addr_mem_q[rd_ptr_q];
    head_data_o = data_mem_q[rd_ptr_q];
  end

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the current count.
  always_comb begin
    ent_valid_o = '0;
    ent_addr_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off            = PTR_W'(i) - rd_ptr_q;
      ent_valid_o[i] = (CNT_W'(off) < count_q);
      ent_addr_o[i]  = addr_mem_q[i];
    end
  end

endmodule

// File: rtl/wb_write_responder.sv
// Responder side of the writeback -> register-file four-phase handshake.
// Accepted writes are queued in wb_fifo and drained as single-cycle strobes
// into the register array; queued writes are compared against the decode
// read addresses to flag hazards.
// Optional build macro: WB_R0_DISCARD_EN -- writes to address 0 are acked but
// never queued, and hazards never assert for address 0.
//   clk, rst              : clock, synchronous active-low reset
//   req / ack             : four-phase request in / acknowledge out (registered)
//   we, wr_addr, wr_data  : transfer payload, sampled on the IDLE->ACKED edge
//   rf_we, rf_addr, rf_data, rf_ready : array write port (pop on rf_we&rf_ready)
//   addr_r1/2, hazard_r1/2 : decode read addresses and pending-write flags
//   full, empty           : FIFO occupancy
module wb_write_responder
  import async_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ack,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] addr_r1,
  input  logic [ADDR_W-1:0] addr_r2,
  output logic              hazard_r1,
  output logic              hazard_r2,
  output logic              full,
  output logic              empty
);

  hs_state_t state_q;
  logic      ack_q;

  logic                         push, pop;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;

  // Capture happens only on the IDLE->ACKED transition.
  always_comb begin
    push = (state_q == HS_IDLE) && req && !full && we;
`ifdef WB_R0_DISCARD_EN
    if (wr_addr == '0) push = 1'b0;
`endif
    pop = rf_we && rf_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= HS_IDLE;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        HS_IDLE: begin
          if (req && !full) begin
            state_q <= HS_ACKED;
            ack_q   <= 1'b1;
          end
        end
        HS_ACKED: begin
          if (!req) begin
            state_q <= HS_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= HS_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack = ack_q;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (full),
    .empty_o     (empty),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  // Head storage is stale when empty, so the array port is forced to zero.
  always_comb begin
    rf_we   = ~empty;
    rf_addr = empty ? '0 : head_addr;
    rf_data = empty ? '0 : head_data;
  end

  // The entry popped this cycle is still valid here, so it still flags.
  always_comb begin
    hazard_r1 = 1'b0;
    hazard_r2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == addr_r1)) hazard_r1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == addr_r2)) hazard_r2 = 1'b1;
    end
`ifdef WB_R0_DISCARD_EN
    if (addr_r1 == '0) hazard_r1 = 1'b0;
    if (addr_r2 == '0) hazard_r2 = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wb_write_responder.sv
module tb_wb_write_responder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              ack;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_ready;
  logic [ADDR_W-1:0] addr_r1;
  logic [ADDR_W-1:0] addr_r2;
  logic              hazard_r1;
  logic              hazard_r2;
  logic              full;
  logic              empty;

  int total = 0;
  int bad   = 0;

  wb_write_responder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .rf_ready  (rf_ready),
    .addr_r1   (addr_r1),
    .addr_r2   (addr_r2),
    .hazard_r1 (hazard_r1),
    .hazard_r2 (hazard_r2),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase transfer with a bounded wait for ack.
  task automatic xfer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    wr_addr = a;
    wr_data = d;
    we      = 1'b1;
    req     = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 20);
    chk("xfer_ack", 32'(ack), 32'd1);
    req = 1'b0;
    tick();
    chk("xfer_ack_drop", 32'(ack), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    rf_ready = 1'b0; addr_r1 = '0; addr_r2 = '0;
    tick(); tick();
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_rfwe",  32'(rf_we),     32'd0);
    chk("rst_addr",  32'(rf_addr),   32'd0);
    chk("rst_data",  32'(rf_data),   32'd0);
    chk("rst_haz1",  32'(hazard_r1), 32'd0);
    chk("rst_haz2",  32'(hazard_r2), 32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    rst = 1'b1;
    tick();

    // Single write with the array always ready.
    rf_ready = 1'b1;
    req = 1'b1; we = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    #1 chk("sw_ack_pre", 32'(ack), 32'd0);
    tick();
    chk("sw_ack",   32'(ack),     32'd1);
    chk("sw_rfwe",  32'(rf_we),   32'd1);
    chk("sw_addr",  32'(rf_addr), 32'd5);
    chk("sw_data",  32'(rf_data), 32'hBEEF);
    req = 1'b0;
    tick();
    chk("sw_ack_drop", 32'(ack),   32'd0);
    chk("sw_rfwe_end", 32'(rf_we), 32'd0);
    chk("sw_empty",    32'(empty), 32'd1);

    // Backpressure: two fill the FIFO, the third waits.
    rf_ready = 1'b0;
    xfer(4'd1, 16'h0011);
    xfer(4'd2, 16'h0022);
    chk("bp_full", 32'(full),    32'd1);
    chk("bp_head", 32'(rf_addr), 32'd1);
    wr_addr = 4'd3; wr_data = 16'h0033; req = 1'b1;
    tick(); tick(); tick();
    chk("bp_held_ack",  32'(ack),  32'd0);
    chk("bp_held_full", 32'(full), 32'd1);
    rf_ready = 1'b1;
    #1 chk("bp_out1_addr", 32'(rf_addr), 32'd1);
    chk("bp_out1_data", 32'(rf_data), 32'h0011);
    tick();
    chk("bp_ack_after_pop", 32'(ack), 32'd0);
    chk("bp_out2_addr", 32'(rf_addr), 32'd2);
    chk("bp_out2_data", 32'(rf_data), 32'h0022);
    tick();
    chk("bp_third_ack", 32'(ack),     32'd1);
    chk("bp_out3_addr", 32'(rf_addr), 32'd3);
    chk("bp_out3_data", 32'(rf_data), 32'h0033);
    req = 1'b0;
    tick();
    chk("bp_drained", 32'(empty), 32'd1);
    chk("bp_ack_end", 32'(ack),   32'd0);

    // Null transfer.
    we = 1'b0; wr_addr = 4'd7; wr_data = 16'h7777; req = 1'b1;
    tick();
    chk("null_ack",   32'(ack),   32'd1);
    chk("null_empty", 32'(empty), 32'd1);
    chk("null_rfwe",  32'(rf_we), 32'd0);
    req = 1'b0;
    tick();
    chk("null_ack_drop", 32'(ack),   32'd0);
    chk("null_rfwe2",    32'(rf_we), 32'd0);
    we = 1'b1;

    // Hazard on a queued write, held through the popping cycle.
    rf_ready = 1'b0; addr_r1 = 4'd4; addr_r2 = 4'd9;
    xfer(4'd4, 16'h0044);
    chk("hz_r1", 32'(hazard_r1), 32'd1);
    chk("hz_r2", 32'(hazard_r2), 32'd0);
    rf_ready = 1'b1;
    #1 chk("hz_r1_popping", 32'(hazard_r1), 32'd1);
    tick();
    chk("hz_r1_after", 32'(hazard_r1), 32'd0);
    chk("hz_r2_after", 32'(hazard_r2), 32'd0);
    chk("hz_empty",    32'(empty),     32'd1);

    // Reset in the middle of a handshake.
    rf_ready = 1'b0;
    wr_addr = 4'd6; wr_data = 16'h0066; req = 1'b1;
    tick();
    chk("mr_ack",   32'(ack),   32'd1);
    chk("mr_empty", 32'(empty), 32'd0);
    rst = 1'b0;
    tick();
    chk("mr_rst_ack",   32'(ack),   32'd0);
    chk("mr_rst_empty", 32'(empty), 32'd1);
    chk("mr_rst_rfwe",  32'(rf_we), 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_fresh_ack",  32'(ack),     32'd1);
    chk("mr_fresh_addr", 32'(rf_addr), 32'd6);
    req = 1'b0; rf_ready = 1'b1;
    tick();
    chk("mr_drained", 32'(empty), 32'd1);

    // Write to register 0.
    rf_ready = 1'b0; addr_r1 = 4'd0; addr_r2 = 4'd9;
    wr_addr = 4'd0; wr_data = 16'h1234; req = 1'b1;
    tick();
    chk("r0_ack", 32'(ack), 32'd1);
`ifdef WB_R0_DISCARD_EN
    chk("r0_rfwe",  32'(rf_we),     32'd0);
    chk("r0_empty", 32'(empty),     32'd1);
    chk("r0_haz1",  32'(hazard_r1), 32'd0);
`else
    chk("r0_rfwe",  32'(rf_we),     32'd1);
    chk("r0_addr",  32'(rf_addr),   32'd0);
    chk("r0_data",  32'(rf_data),   32'h1234);
    chk("r0_haz1",  32'(hazard_r1), 32'd1);
`endif
    req = 1'b0; rf_ready = 1'b1;
    tick();
    chk("r0_ack_drop", 32'(ack),   32'd0);
    chk("r0_empty_end", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
